// File: rtl/vm_multi_slot.sv
// Multi-slot vending controller: per-slot prices and stock, credit accumulation,
// cancel/refund, change return after each vend, and a saturating restock port.
module vm_multi_slot #(
  parameter int NUM_SLOTS  = 8,
  parameter int SEL_W      = 3,
  parameter int CREDIT_W   = 8,
  parameter int STOCK_W    = 4,
  parameter int INIT_STOCK = 5,
  parameter logic [NUM_SLOTS*CREDIT_W-1:0] PRICES =
    {8'd40, 8'd35, 8'd30, 8'd25, 8'd20, 8'd15, 8'd10, 8'd5},
  parameter int MAX_CREDIT = 100
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 coin_valid,
  input  logic [3:0]           coin_input,
  input  logic                 select_valid,
  input  logic [SEL_W-1:0]     product_input,
  input  logic                 cancel,
  input  logic                 restock,
  input  logic [SEL_W-1:0]     restock_slot,
  input  logic [STOCK_W-1:0]   restock_qty,
  output logic [CREDIT_W-1:0]  credit,
  output logic                 vend_valid,
  output logic [NUM_SLOTS-1:0] led_output,
  output logic                 change_valid,
  output logic [CREDIT_W-1:0]  change_return,
  output logic                 coin_reject,
  output logic                 sold_out,
  output logic                 insufficient,
  output logic [NUM_SLOTS-1:0] inventory,
  output logic                 inventory_empty
);

  typedef enum logic [1:0] {IDLE, VEND, CHANGE} state_t;

  localparam logic [STOCK_W-1:0]  STOCK_MAX  = '1;
  localparam logic [STOCK_W-1:0]  STOCK_INIT = STOCK_W'(INIT_STOCK);
  localparam logic [CREDIT_W:0]   CREDIT_CAP = (CREDIT_W+1)'(MAX_CREDIT);

  function automatic logic [CREDIT_W-1:0] price_of(input logic [SEL_W-1:0] idx);
    price_of = '0;
    for (int i = 0; i < NUM_SLOTS; i++)
      if (idx == SEL_W'(i)) price_of = PRICES[i*CREDIT_W +: CREDIT_W];
  endfunction

  function automatic logic [STOCK_W-1:0] sat_stock(input logic [STOCK_W:0] v);
    sat_stock = (v > {1'b0, STOCK_MAX}) ? STOCK_MAX : v[STOCK_W-1:0];
  endfunction

  state_t              state;
  logic [STOCK_W-1:0]  stock      [NUM_SLOTS];
  logic [STOCK_W-1:0]  stock_next [NUM_SLOTS];
  logic [STOCK_W-1:0]  sel_stock;
  logic [CREDIT_W-1:0] sel_price;
  logic [CREDIT_W:0]   coin_sum;
  logic [NUM_SLOTS-1:0] inv_now;
  logic                coin_evt;
  logic                sel_ok;
  logic                restock_ok;
  logic                idle;
  logic                coin_accept;
  logic                vend_go;

  assign idle       = (state == IDLE);
  assign coin_evt   = coin_valid && (coin_input != 4'd0);
  assign sel_ok     = ({{(32-SEL_W){1'b0}}, product_input} < 32'(NUM_SLOTS));
  assign restock_ok = ({{(32-SEL_W){1'b0}}, restock_slot} < 32'(NUM_SLOTS));
  assign sel_price  = price_of(product_input);
  // Sum is one bit wider than credit so an over-ceiling coin can never wrap.
  assign coin_sum   = {1'b0, credit} + (CREDIT_W+1)'(coin_input);

  // A coin only counts when it is the sole request in IDLE and stays under the ceiling.
  assign coin_accept = idle && !cancel && !select_valid && coin_evt &&
                       (coin_sum <= CREDIT_CAP);
  assign vend_go     = idle && !cancel && select_valid && sel_ok &&
                       (sel_stock != '0) && (credit >= sel_price);

  always_comb begin
    sel_stock = '0;
    for (int i = 0; i < NUM_SLOTS; i++)
      if (product_input == SEL_W'(i)) sel_stock = stock[i];
  end

  // Vend decrement and restock may hit the same slot; both apply before saturation.
  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      stock_next[i] = sat_stock({1'b0, stock[i]}
        - {{STOCK_W{1'b0}}, (vend_go && product_input == SEL_W'(i))}
        + {1'b0, ((restock && restock_ok && restock_slot == SEL_W'(i))
                  ? restock_qty : {STOCK_W{1'b0}})});
      inv_now[i] = (stock[i] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      credit          <= '0;
      vend_valid      <= 1'b0;
      led_output      <= '0;
      change_valid    <= 1'b0;
      change_return   <= '0;
      coin_reject     <= 1'b0;
      sold_out        <= 1'b0;
      insufficient    <= 1'b0;
      inventory       <= {NUM_SLOTS{INIT_STOCK != 0}};
      inventory_empty <= (INIT_STOCK == 0);
      for (int i = 0; i < NUM_SLOTS; i++) stock[i] <= STOCK_INIT;
    end else begin
      vend_valid      <= 1'b0;
      led_output      <= '0;
      change_valid    <= 1'b0;
      change_return   <= '0;
      sold_out        <= 1'b0;
      insufficient    <= 1'b0;
      coin_reject     <= coin_evt && !coin_accept;
      stock           <= stock_next;
      inventory       <= inv_now;
      inventory_empty <= ~|inv_now;

      case (state)
        IDLE: begin
          if (cancel) begin
            if (credit != '0) begin
              change_valid  <= 1'b1;
              change_return <= credit;
            end
            credit <= '0;
          end else if (select_valid) begin
            if (sel_ok) begin
              if (sel_stock == '0) begin
                sold_out <= 1'b1;
              end else if (credit < sel_price) begin
                insufficient <= 1'b1;
              end else begin
                state      <= VEND;
                vend_valid <= 1'b1;
                led_output <= NUM_SLOTS'(1) << product_input;
                credit     <= credit - sel_price;
              end
            end
          end else if (coin_accept) begin
            credit <= coin_sum[CREDIT_W-1:0];
          end
        end
        // Change is registered on leaving VEND so it appears the cycle after the dispense pulse.
        VEND: begin
          state <= CHANGE;
          if (credit != '0) begin
            change_valid  <= 1'b1;
            change_return <= credit;
          end
          credit <= '0;
        end
        CHANGE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vm_multi_slot.sv
// Directed bench for vm_multi_slot: hand-computed vectors for credit, vend, change,
// reject, sold-out, restock saturation and reset during a vend.
module tb_vm_multi_slot;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       coin_valid = 1'b0;
  logic [3:0] coin_input = '0;
  logic       select_valid = 1'b0;
  logic [2:0] product_input = '0;
  logic       cancel = 1'b0;
  logic       restock = 1'b0;
  logic [2:0] restock_slot = '0;
  logic [3:0] restock_qty = '0;
  logic [7:0] credit;
  logic       vend_valid;
  logic [7:0] led_output;
  logic       change_valid;
  logic [7:0] change_return;
  logic       coin_reject;
  logic       sold_out;
  logic       insufficient;
  logic [7:0] inventory;
  logic       inventory_empty;

  int checks = 0;
  int failures = 0;

  vm_multi_slot dut (
    .clk(clk), .reset(reset),
    .coin_valid(coin_valid), .coin_input(coin_input),
    .select_valid(select_valid), .product_input(product_input),
    .cancel(cancel), .restock(restock),
    .restock_slot(restock_slot), .restock_qty(restock_qty),
    .credit(credit), .vend_valid(vend_valid), .led_output(led_output),
    .change_valid(change_valid), .change_return(change_return),
    .coin_reject(coin_reject), .sold_out(sold_out), .insufficient(insufficient),
    .inventory(inventory), .inventory_empty(inventory_empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_coin(input logic [3:0] v);
    coin_valid = 1'b1;
    coin_input = v;
    tick();
    coin_valid = 1'b0;
    coin_input = '0;
  endtask

  task automatic pick(input logic [2:0] s);
    select_valid  = 1'b1;
    product_input = s;
    tick();
    select_valid  = 1'b0;
  endtask

  task automatic do_cancel();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
  endtask

  task automatic do_restock(input logic [2:0] s, input logic [3:0] q);
    restock      = 1'b1;
    restock_slot = s;
    restock_qty  = q;
    tick();
    restock      = 1'b0;
    restock_qty  = '0;
  endtask

  initial begin
    tick();
    tick();
    check("rst_credit", 32'(credit), 0);
    check("rst_inventory", 32'(inventory), 32'hFF);
    check("rst_empty", 32'(inventory_empty), 0);
    check("rst_vend", 32'(vend_valid), 0);
    reset = 1'b0;
    tick();

    // Select with no credit
    pick(3'd0);
    check("insuff_pulse", 32'(insufficient), 1);
    check("insuff_credit", 32'(credit), 0);
    check("insuff_vend", 32'(vend_valid), 0);

    // 5+5+2 then buy slot1 (price 10)
    put_coin(4'd5);
    put_coin(4'd5);
    put_coin(4'd2);
    check("credit12", 32'(credit), 12);
    pick(3'd1);
    check("vend1_valid", 32'(vend_valid), 1);
    check("vend1_led", 32'(led_output), 32'h02);
    check("vend1_credit", 32'(credit), 2);
    tick();
    check("chg1_valid", 32'(change_valid), 1);
    check("chg1_amount", 32'(change_return), 2);
    check("chg1_credit", 32'(credit), 0);
    check("chg1_led_clear", 32'(led_output), 0);
    tick();
    check("slot1_stock", 32'(dut.stock[1]), 4);

    // Cancel refund of 20
    put_coin(4'd10);
    put_coin(4'd10);
    do_cancel();
    check("cancel_valid", 32'(change_valid), 1);
    check("cancel_amount", 32'(change_return), 20);
    check("cancel_novend", 32'(vend_valid), 0);
    check("cancel_credit", 32'(credit), 0);

    // Credit ceiling
    for (int i = 0; i < 6; i++) put_coin(4'd15);
    put_coin(4'd8);
    check("credit98", 32'(credit), 98);
    put_coin(4'd4);
    check("over_reject", 32'(coin_reject), 1);
    check("over_credit", 32'(credit), 98);
    put_coin(4'd2);
    check("cap_noreject", 32'(coin_reject), 0);
    check("cap_credit", 32'(credit), 100);
    do_cancel();
    check("cap_refund", 32'(change_return), 100);

    // Drain slot0
    for (int i = 0; i < 5; i++) begin
      put_coin(4'd5);
      pick(3'd0);
      check("drain_vend", 32'(vend_valid), 1);
      tick();
      tick();
    end
    check("drained_inv", 32'(inventory), 32'hFE);
    put_coin(4'd5);
    pick(3'd0);
    check("soldout_pulse", 32'(sold_out), 1);
    check("soldout_novend", 32'(vend_valid), 0);
    check("soldout_credit", 32'(credit), 5);
    do_restock(3'd0, 4'd3);
    check("restock3_stock", 32'(dut.stock[0]), 3);
    tick();
    check("restock3_inv", 32'(inventory), 32'hFF);
    do_restock(3'd0, 4'd15);
    check("restock_sat", 32'(dut.stock[0]), 15);
    do_cancel();
    check("refund5", 32'(change_return), 5);

    // Coin with select, then coin during VEND
    put_coin(4'd15);
    coin_valid = 1'b1;
    coin_input = 4'd5;
    select_valid = 1'b1;
    product_input = 3'd1;
    tick();
    coin_valid = 1'b0;
    coin_input = '0;
    select_valid = 1'b0;
    check("cosel_reject", 32'(coin_reject), 1);
    check("cosel_vend", 32'(vend_valid), 1);
    check("cosel_credit", 32'(credit), 5);
    put_coin(4'd5);
    check("busy_reject", 32'(coin_reject), 1);
    check("busy_chg_valid", 32'(change_valid), 1);
    check("busy_chg_amount", 32'(change_return), 5);
    tick();

    // Reset during VEND
    put_coin(4'd10);
    pick(3'd1);
    check("prerst_vend", 32'(vend_valid), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstv_vend", 32'(vend_valid), 0);
    check("rstv_led", 32'(led_output), 0);
    check("rstv_credit", 32'(credit), 0);
    check("rstv_chg", 32'(change_valid), 0);
    check("rstv_inventory", 32'(inventory), 32'hFF);
    tick();
    check("rstv_nochg", 32'(change_valid), 0);
    check("rstv_stock0", 32'(dut.stock[0]), 5);

    // Vend and restock on the same slot in the same cycle
    put_coin(4'd10);
    restock = 1'b1;
    restock_slot = 3'd1;
    restock_qty = 4'd2;
    pick(3'd1);
    restock = 1'b0;
    restock_qty = '0;
    check("both_vend", 32'(vend_valid), 1);
    check("both_stock", 32'(dut.stock[1]), 6);
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
